// File: rtl/jt49_env.sv
// jt49_env: YM2149 envelope generator (32 steps), AY-3-8910 16-step mode when JT49_ENV_AY_EN is defined
module jt49_env #(
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cen256,
   input  logic                restart,
   input  logic [PERIOD_W-1:0] period,
   input  logic [3:0]          shape,
   output logic [4:0]          env,
   output logic                hold
);
`ifdef JT49_ENV_AY_EN
   localparam logic [4:0] STEP_INC = 5'd2;
   localparam logic [4:0] LAST     = 5'd30;
`else
   localparam logic [4:0] STEP_INC = 5'd1;
   localparam logic [4:0] LAST     = 5'd31;
`endif
   typedef enum logic {ST_RUN, ST_HOLD} state_t;
   state_t              state;
   logic [PERIOD_W-1:0] pcnt, peff;
   logic [4:0]          step, nstep;
   logic                inv, ninv, tick;
   assign peff  = period == '0 ? PERIOD_W'(1) : period;
   assign tick  = ({1'b0, pcnt} + (PERIOD_W+1)'(1)) >= {1'b0, peff};
   assign nstep = step + STEP_INC;
   assign ninv  = inv ^ shape[1];
   // restart wins over everything; otherwise advance on cen256 while running, shape read live at end of cycle
   always_ff @(negedge clk or negedge rst_n)
      if (!rst_n) begin
         pcnt  <= '0;
         step  <= '0;
         inv   <= 1'b0;
         state <= ST_HOLD;
         env   <= '0;
         hold  <= 1'b1;
      end else if (restart) begin
         pcnt  <= '0;
         step  <= '0;
         inv   <= ~shape[2];
         state <= ST_RUN;
         env   <= {5{~shape[2]}};
         hold  <= 1'b0;
      end else if (state == ST_RUN && cen256) begin
         if (!tick) pcnt <= pcnt + PERIOD_W'(1);
         else begin
            pcnt <= '0;
            if (step != LAST) begin
               step <= nstep;
               env  <= nstep ^ {5{inv}};
            end else if (!shape[3]) begin
               state <= ST_HOLD;
               hold  <= 1'b1;
               env   <= '0;
            end else if (shape[0]) begin
               state <= ST_HOLD;
               hold  <= 1'b1;
               env   <= {5{shape[2] ^ shape[1]}};
            end else begin
               step <= '0;
               inv  <= ninv;
               env  <= {5{ninv}};
            end
         end
      end
endmodule

// File: tb/tb_jt49_env.sv
// tb_jt49_env: directed self-checking bench for jt49_env (follows JT49_ENV_AY_EN if defined)
module tb_jt49_env;
`ifdef JT49_ENV_AY_EN
   localparam int INC = 2;
`else
   localparam int INC = 1;
`endif
   localparam int NL = 32 / INC;
   logic        clk = 0, rst_n = 0, cen256 = 0, restart = 0;
   logic [15:0] period = 16'd1;
   logic [3:0]  shape = 4'h0;
   logic [4:0]  env;
   logic        hold;
   int          checks = 0, errors = 0;

   jt49_env #(.PERIOD_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .cen256(cen256), .restart(restart),
      .period(period), .shape(shape), .env(env), .hold(hold)
   );

   always #5 clk = ~clk;

   task automatic cen(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk) cen256 = 1;
         @(posedge clk) cen256 = 0;
      end
   endtask

   task automatic do_restart(input logic [3:0] s, input logic [15:0] p);
      @(posedge clk) begin shape = s; period = p; restart = 1; end
      @(posedge clk) restart = 0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      checks++;
      if (env !== 5'd0 || hold !== 1'b1) begin
         errors++; $display("FAIL reset: env=%0d hold=%b, want env=0 hold=1", env, hold);
      end
      @(posedge clk) rst_n = 1;
      cen(3);
      checks++;
      if (env !== 5'd0 || hold !== 1'b1) begin
         errors++; $display("FAIL reset_idle: env=%0d hold=%b, want env=0 hold=1", env, hold);
      end
   endtask

   task automatic test_attack_hold;
      do_restart(4'hD, 16'd1);
      checks++;
      if (env !== 5'd0 || hold !== 1'b0) begin
         errors++; $display("FAIL attack_start: env=%0d hold=%b, want env=0 hold=0", env, hold);
      end
      for (int k = 1; k < NL; k++) begin
         cen(1);
         checks++;
         if (env !== 5'(k * INC)) begin
            errors++; $display("FAIL attack_level%0d: env=%0d want %0d", k, env, k * INC);
         end
      end
      cen(1);
      checks++;
      if (env !== 5'd31 || hold !== 1'b1) begin
         errors++; $display("FAIL attack_hold: env=%0d hold=%b, want env=31 hold=1", env, hold);
      end
      cen(3);
      checks++;
      if (env !== 5'd31 || hold !== 1'b1) begin
         errors++; $display("FAIL attack_frozen: env=%0d hold=%b, want env=31 hold=1", env, hold);
      end
   endtask

   task automatic test_decay;
      do_restart(4'h0, 16'd3);
      checks++;
      if (env !== 5'd31) begin
         errors++; $display("FAIL decay_start: env=%0d want 31", env);
      end
      for (int k = 1; k < NL; k++) begin
         cen(2);
         checks++;
         if (env !== 5'(31 - (k - 1) * INC)) begin
            errors++; $display("FAIL decay_dwell%0d: env=%0d want %0d", k, env, 31 - (k - 1) * INC);
         end
         cen(1);
         checks++;
         if (env !== 5'(31 - k * INC)) begin
            errors++; $display("FAIL decay_level%0d: env=%0d want %0d", k, env, 31 - k * INC);
         end
      end
      cen(2);
      checks++;
      if (hold !== 1'b0) begin
         errors++; $display("FAIL decay_early_hold: hold=%b want 0", hold);
      end
      cen(1);
      checks++;
      if (env !== 5'd0 || hold !== 1'b1) begin
         errors++; $display("FAIL decay_hold: env=%0d hold=%b, want env=0 hold=1", env, hold);
      end
   endtask

   task automatic test_triangle;
      do_restart(4'hE, 16'd1);
      for (int c = 0; c < 3; c++)
         for (int k = (c == 0) ? 1 : 0; k < NL; k++) begin
            logic [4:0] exp_env;
            exp_env = 5'(k * INC) ^ {5{c[0]}};
            cen(1);
            checks++;
            if (env !== exp_env || hold !== 1'b0) begin
               errors++; $display("FAIL triangle_c%0d_k%0d: env=%0d hold=%b, want env=%0d hold=0", c, k, env, hold, exp_env);
            end
         end
   endtask

   task automatic test_hold_shapes;
      do_restart(4'hB, 16'd1);
      cen(NL - 1);
      checks++;
      if (env !== 5'(31 - (NL - 1) * INC)) begin
         errors++; $display("FAIL shapeB_bottom: env=%0d want %0d", env, 31 - (NL - 1) * INC);
      end
      cen(1);
      checks++;
      if (env !== 5'd31 || hold !== 1'b1) begin
         errors++; $display("FAIL shapeB_hold: env=%0d hold=%b, want env=31 hold=1", env, hold);
      end
      do_restart(4'hF, 16'd1);
      cen(NL - 1);
      checks++;
      if (env !== 5'((NL - 1) * INC)) begin
         errors++; $display("FAIL shapeF_top: env=%0d want %0d", env, (NL - 1) * INC);
      end
      cen(1);
      checks++;
      if (env !== 5'd0 || hold !== 1'b1) begin
         errors++; $display("FAIL shapeF_hold: env=%0d hold=%b, want env=0 hold=1", env, hold);
      end
   endtask

   task automatic test_period;
      do_restart(4'hD, 16'd0);
      cen(1);
      checks++;
      if (env !== 5'(INC)) begin
         errors++; $display("FAIL period0_step1: env=%0d want %0d", env, INC);
      end
      cen(1);
      checks++;
      if (env !== 5'(2 * INC)) begin
         errors++; $display("FAIL period0_step2: env=%0d want %0d", env, 2 * INC);
      end
      do_restart(4'hD, 16'd100);
      cen(50);
      checks++;
      if (env !== 5'd0) begin
         errors++; $display("FAIL period100_wait: env=%0d want 0", env);
      end
      period = 16'd2;
      cen(1);
      checks++;
      if (env !== 5'(INC)) begin
         errors++; $display("FAIL period_drop: env=%0d want %0d", env, INC);
      end
      cen(1);
      checks++;
      if (env !== 5'(INC)) begin
         errors++; $display("FAIL period2_dwell: env=%0d want %0d", env, INC);
      end
      cen(1);
      checks++;
      if (env !== 5'(2 * INC)) begin
         errors++; $display("FAIL period2_step: env=%0d want %0d", env, 2 * INC);
      end
   endtask

   task automatic test_restart_cen;
      do_restart(4'h0, 16'd2);
      cen(2 * (14 / INC) + 1);
      checks++;
      if (env !== 5'd17) begin
         errors++; $display("FAIL restart_pre: env=%0d want 17", env);
      end
      @(posedge clk) begin restart = 1; cen256 = 1; end
      @(posedge clk) begin restart = 0; cen256 = 0; end
      checks++;
      if (env !== 5'd31 || hold !== 1'b0) begin
         errors++; $display("FAIL restart_cen: env=%0d hold=%b, want env=31 hold=0", env, hold);
      end
      cen(1);
      checks++;
      if (env !== 5'd31) begin
         errors++; $display("FAIL restart_pcnt_clear: env=%0d want 31", env);
      end
      cen(1);
      checks++;
      if (env !== 5'(31 - INC)) begin
         errors++; $display("FAIL restart_next_step: env=%0d want %0d", env, 31 - INC);
      end
   endtask

   task automatic test_async_reset;
      do_restart(4'hD, 16'd1);
      cen(5);
      checks++;
      if (env !== 5'(5 * INC)) begin
         errors++; $display("FAIL async_pre: env=%0d want %0d", env, 5 * INC);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if (env !== 5'd0 || hold !== 1'b1) begin
         errors++; $display("FAIL async_reset: env=%0d hold=%b, want env=0 hold=1", env, hold);
      end
      @(posedge clk) rst_n = 1;
   endtask

   initial begin
      test_reset;
      test_attack_hold;
      test_decay;
      test_triangle;
      test_hold_shapes;
      test_period;
      test_restart_cen;
      test_async_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
